// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: opcodes, FSM states, decode.
// Latency: n/a (package only).
// Backpressure: n/a.
// Optional feature macro: ALU_SLTU_EN (decodes ctrl 1011 as SLTU when defined).
package alu_pkg;

  // ALU control opcodes as seen on ctrl_i
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLTU = 4'b1011;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;

  // Operation selector of one digit slice
  localparam logic [1:0] DOP_AND  = 2'b00;
  localparam logic [1:0] DOP_OR   = 2'b01;
  localparam logic [1:0] DOP_ADD  = 2'b10;
  localparam logic [1:0] DOP_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Decoded control, captured once at accept
  typedef struct packed {
    logic       valid;
    logic [1:0] dop;
    logic       a_inv;
    logic       b_inv;
    logic       slt;
    logic       sltu;
  } dec_t;

  function automatic int clog2(input int value);
    int w;
    for (w = 0; (1 << w) < value; w++) begin
    end
    return w;
  endfunction

  // Unknown opcodes decode to valid=0 with a slice op that yields zero.
  function automatic dec_t decode(input logic [3:0] ctrl);
    dec_t d;
    d     = '0;
    d.dop = DOP_ZERO;
    case (ctrl)
      CTRL_AND: begin d.valid = 1'b1; d.dop = DOP_AND; end
      CTRL_OR:  begin d.valid = 1'b1; d.dop = DOP_OR;  end
      CTRL_ADD: begin d.valid = 1'b1; d.dop = DOP_ADD; end
      CTRL_SUB: begin d.valid = 1'b1; d.dop = DOP_ADD; d.b_inv = 1'b1; end
      CTRL_SLT: begin d.valid = 1'b1; d.dop = DOP_ADD; d.b_inv = 1'b1; d.slt = 1'b1; end
      // NOR as AND of both inverted operands
      CTRL_NOR: begin d.valid = 1'b1; d.dop = DOP_AND; d.a_inv = 1'b1; d.b_inv = 1'b1; end
      CTRL_SLTU: begin
`ifdef ALU_SLTU_EN
        d.valid = 1'b1;
        d.dop   = DOP_ADD;
        d.b_inv = 1'b1;
        d.sltu  = 1'b1;
`endif
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_digit.sv
// One DIGIT-wide ALU slice built from chained 1-bit slices (AND / OR / full add).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: a, b digit operands; a_invert, b_invert operand inversion; cin ripple carry in;
//        op slice operation; res digit result; cout carry out; cin_top carry into top bit.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             cin_top
);

  logic [DIGIT-1:0] a_eff;
  logic [DIGIT-1:0] b_eff;
  logic [DIGIT-1:0] sum;
  logic [DIGIT:0]   carry;

  assign a_eff    = a ^ {DIGIT{a_invert}};
  assign b_eff    = b ^ {DIGIT{b_invert}};
  assign carry[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]       = a_eff[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1]   = (a_eff[i] & b_eff[i]) | (carry[i] & (a_eff[i] ^ b_eff[i]));
  end

  assign cout    = carry[DIGIT];
  assign cin_top = carry[DIGIT-1];

  always_comb begin
    res = '0;
    case (op)
      DOP_AND: res = a_eff & b_eff;
      DOP_OR:  res = a_eff | b_eff;
      DOP_ADD: res = sum;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: DIGIT bits per clock, LSB first, with SLT fix-up and zero/carry/overflow flags.
// Latency: done_o pulses WIDTH/DIGIT + 1 cycles after the accepting edge.
// Backpressure: start_i is ignored while busy_o is high; next accept is the cycle after done_o.
// Ports: clk_i, rst_i (async, active-high); start_i, src1_i, src2_i, ctrl_i request;
//        busy_o, done_o handshake; result_o, zero_o, cout_o, overflow_o held until next completion.
// Optional feature macro: ALU_SLTU_EN (ctrl 1011 = unsigned set-less-than).
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("alu_serial: WIDTH must be a multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic             accept;
  logic             last_digit;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b, res_sh, res_next;
  dec_t             dec_in, dec_q;
  logic             carry_q, cin_msb_q, cout_msb_q;
  logic [DIGIT-1:0] dig_res;
  logic             dig_cout, dig_cin_top;
  logic             ovf;
  logic [WIDTH-1:0] fix_result;
  logic             fix_cout, fix_ovf;

  assign dec_in     = decode(ctrl_i);
  assign last_digit = (cnt == CNT_W'(NDIG - 1));
  // done_o is registered, so the FSM is back in IDLE during the done cycle; busy covers it.
  assign busy_o     = (state != ST_IDLE) || done_o;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (op_a[DIGIT-1:0]),
    .b        (op_b[DIGIT-1:0]),
    .a_invert (dec_q.a_inv),
    .b_invert (dec_q.b_inv),
    .cin      (carry_q),
    .op       (dec_q.dop),
    .res      (dig_res),
    .cout     (dig_cout),
    .cin_top  (dig_cin_top)
  );

  // New digit enters at the top; after NDIG shifts digit 0 sits at the LSB.
  assign res_next = (res_sh >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = start_i && !done_o;
        if (accept) state_nxt = ST_RUN;
      end
      ST_RUN:  if (last_digit) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Final result/flag selection, evaluated in the FIX cycle
  always_comb begin
    ovf        = cin_msb_q ^ cout_msb_q;
    fix_result = '0;
    fix_cout   = 1'b0;
    fix_ovf    = 1'b0;
    if (!dec_q.valid) begin
      fix_result = '0;
    end else if (dec_q.slt) begin
      // sign of the difference, corrected when the subtraction overflowed
      fix_result[0] = res_sh[WIDTH-1] ^ ovf;
      fix_cout      = cout_msb_q;
    end else if (dec_q.sltu) begin
      fix_result[0] = ~cout_msb_q;
      fix_cout      = cout_msb_q;
    end else if (dec_q.dop == DOP_ADD) begin
      fix_result = res_sh;
      fix_cout   = cout_msb_q;
      fix_ovf    = ovf;
    end else begin
      fix_result = res_sh;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_a       <= '0;
      op_b       <= '0;
      res_sh     <= '0;
      dec_q      <= '0;
      cnt        <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= (state == ST_FIX);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a    <= src1_i;
            op_b    <= src2_i;
            dec_q   <= dec_in;
            cnt     <= '0;
            // +1 of the two's-complement negate for SUB/SLT/SLTU
            carry_q <= dec_in.b_inv && (dec_in.dop == DOP_ADD);
          end
        end
        ST_RUN: begin
          op_a    <= op_a >> DIGIT;
          op_b    <= op_b >> DIGIT;
          res_sh  <= res_next;
          carry_q <= dig_cout;
          cnt     <= cnt + CNT_W'(1);
          if (last_digit) begin
            cin_msb_q  <= dig_cin_top;
            cout_msb_q <= dig_cout;
          end
        end
        ST_FIX: begin
          result_o   <= fix_result;
          zero_o     <= (fix_result == '0);
          cout_o     <= fix_cout;
          overflow_o <= fix_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=32, DIGIT=4): directed vectors with literal
// expectations plus a cycle-by-cycle comparison against a transaction-level model.
module tb_alu_serial;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int LAT   = WIDTH / DIGIT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [3:0]  ctrl = '0;
  logic        busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_pass   = 0;

  alu_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .src1_i     (src1),
    .src2_i     (src2),
    .ctrl_i     (ctrl),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .cout_o     (cout_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  // Plain arithmetic model of one operation
  function automatic exp_t model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    case (c)
      CTRL_AND: e.res = a & b;
      CTRL_OR:  e.res = a | b;
      CTRL_NOR: e.res = ~(a | b);
      CTRL_ADD: begin
        s      = {1'b0, a} + {1'b0, b};
        e.res  = s[31:0];
        e.cout = s[32];
        e.ovf  = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      CTRL_SUB: begin
        e.res  = s[31:0];
        e.cout = s[32];
        e.ovf  = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      CTRL_SLT: begin
        e.res  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        e.cout = s[32];
      end
`ifdef ALU_SLTU_EN
      CTRL_SLTU: begin
        e.res  = (a < b) ? 32'd1 : 32'd0;
        e.cout = s[32];
      end
`endif
      default: ;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Transaction-level model: countdown from accept to completion
  int   m_cnt  = 0;
  logic m_done = 1'b0;
  exp_t m_out  = '0;
  exp_t m_pend = '0;

  always @(posedge clk or posedge rst) begin
    logic was_done;
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_out  = m_pend;
        end
      end else if (start && !was_done) begin
        m_pend = model_op(ctrl, src1, src2);
        m_cnt  = LAT;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = (m_cnt != 0) || m_done;
    n_checks++;
    if (busy_o === exp_busy && done_o === m_done && result_o === m_out.res &&
        zero_o === m_out.zero && cout_o === m_out.cout && overflow_o === m_out.ovf)
      n_pass++;
    else
      $display("FAIL cycle_model t=%0t busy/done/res/z/c/v got %b/%b/%h/%b/%b/%b want %b/%b/%h/%b/%b/%b",
               $time, busy_o, done_o, result_o, zero_o, cout_o, overflow_o,
               exp_busy, m_done, m_out.res, m_out.zero, m_out.cout, m_out.ovf);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic cout, input logic ovf, input logic zero);
    vec_t v;
    v.c = c; v.a = a; v.b = b; v.res = res; v.cout = cout; v.ovf = ovf; v.zero = zero;
    return v;
  endfunction

  // Issue one op, scramble the inputs after accept, and check the completion against literals.
  task automatic run_op(input vec_t v, input string name);
    int   k;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; ctrl = v.c; src1 = v.a; src2 = v.b;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom);
    k = 0; seen = 1'b0;
    while (!seen && k < 3 * LAT) begin
      @(posedge clk); #1;
      k++;
      seen = done_o;
    end
    check({name, "_latency"}, 32'(k), 32'(LAT));
    check({name, "_result"}, result_o, v.res);
    check({name, "_cout"}, 32'(cout_o), 32'(v.cout));
    check({name, "_ovf"}, 32'(overflow_o), 32'(v.ovf));
    check({name, "_zero"}, 32'(zero_o), 32'(v.zero));
  endtask

  vec_t vecs[$];

  initial begin
    int dones;
    int lat;
    logic [31:0] got;

    vecs.push_back(mk(CTRL_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(CTRL_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(CTRL_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(CTRL_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(CTRL_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(CTRL_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(CTRL_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1111,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(CTRL_OR,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(CTRL_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(CTRL_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
`ifdef ALU_SLTU_EN
    vecs.push_back(mk(CTRL_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(CTRL_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1));
`else
    vecs.push_back(mk(CTRL_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(CTRL_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1));
`endif

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 32'h0);
    check("reset_flags", {27'd0, busy_o, done_o, zero_o, cout_o, overflow_o}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // start_i while busy: the second request must be ignored
    @(posedge clk); #1;
    start = 1'b1; ctrl = CTRL_AND; src1 = 32'hF0F0F0F0; src2 = 32'hFF00FF00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; ctrl = CTRL_ADD; src1 = 32'h1; src2 = 32'h2;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; lat = 0; got = '0;
    for (int i = 4; i < 4 + 3 * LAT; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        dones++;
        lat = i;
        got = result_o;
      end
    end
    check("busy_ignore_dones", 32'(dones), 32'd1);
    check("busy_ignore_latency", 32'(lat), 32'(LAT));
    check("busy_ignore_result", got, 32'hF000F000);

    // Reset in the middle of RUN abandons the operation
    @(posedge clk); #1;
    start = 1'b1; ctrl = CTRL_ADD; src1 = 32'h10; src2 = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_result", result_o, 32'h0);
    check("midrst_flags", {27'd0, busy_o, done_o, zero_o, cout_o, overflow_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op(mk(CTRL_ADD, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1'b0), "post_reset_add");

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
